// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// Used by the receiver, the baud generator and the transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned OS_W       = $clog2(OVERSAMPLE);

  // Tick index at which the start bit is qualified (middle of the start bit).
  localparam logic [OS_W-1:0] MID_SAMPLE  = OS_W'(OVERSAMPLE / 2 - 1);
  // Tick index at which data, parity and stop bits are sampled (one bit later).
  localparam logic [OS_W-1:0] LAST_SAMPLE = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rx line synchroniser: SYNC_STAGES flop chain, idle-high reset, plus a
// falling-edge detector on the synchronised line.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  if (SYNC_STAGES < 2) begin : g_param_check
    $error("uart_rx_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the synchroniser and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx_16x.sv
// UART receiver on a 16x oversampling tick: start-bit qualification at
// mid-bit, LSB-first data shift, stop-bit check, valid/ready holding register
// with framing/overrun reporting.
// Optional parity check is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick_16x,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_16x: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
  end

  localparam int unsigned BC_W = $clog2(DATA_BITS);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic [OS_W-1:0]      os_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 done;
  logic                 rx_s;
  logic                 rx_fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .rx_s   (rx_s),
    .rx_fall(rx_fall)
  );

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  // Frame FSM: oversample counting, bit sampling, shift register and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Free-running tick count; state transitions below restart it where needed.
      if (baud_tick_16x) os_cnt <= os_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (rx_fall) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: begin
          if (baud_tick_16x && os_cnt == MID_SAMPLE) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
            state   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (baud_tick_16x && os_cnt == LAST_SAMPLE) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_tick_16x && os_cnt == LAST_SAMPLE) begin
            if (rx_s != ((^shreg) ^ ODD)) begin
              parity_err <= 1'b1;
              par_bad    <= 1'b1;
            end
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_tick_16x && os_cnt == LAST_SAMPLE) begin
            state <= IDLE;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              done <= !par_bad;
`else
              done <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: load a completed byte unless an unread one would be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (rx_valid && !rx_ready) begin
          overrun_err <= 1'b1;
        end else begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
